button_debouncer: RTL
=====================

# button_debouncer

Debounces one already-synchronized pushbutton or switch level and turns it into a clean level plus single-cycle press, release and long-press event pulses. It sits directly downstream of the 2-stage synchronizer: its `sync_in` is driven by the synchronizer's `sync_out`. Its outputs feed control FSMs, which must never see bounce.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive equal samples required to accept a level change. Must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 50000000: cycles after `press_pulse` at which `long_press_pulse` fires. Must be > `DEBOUNCE_CYCLES`.
- `clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `sync_in`, input, 1 bit: synchronized raw level, where 1 means pressed.
- `level`, output, 1 bit: debounced level. Reset value 0.
- `press_pulse`, output, 1 bit: one-cycle pulse on an accepted 0→1 change. Reset value 0.
- `release_pulse`, output, 1 bit: one-cycle pulse on an accepted 1→0 change. Reset value 0.
- `long_press_pulse`, output, 1 bit: one-cycle pulse when a press has been held `LONG_PRESS_CYCLES` cycles. Reset value 0.

## Operation
- FSM states:
  - `S_LOW`: stable 0.
  - `S_RISE`: qualifying a 1.
  - `S_HIGH`: stable 1.
  - `S_FALL`: qualifying a 0.
- Reset value: state `S_LOW`, all counters 0.
- `S_LOW`:
  - `sync_in`=1 → `S_RISE`, `db_cnt`←1.
  - Otherwise stay.
- `S_RISE`:
  - `sync_in`=0 → `S_LOW`, `db_cnt`←0. This is a bounce; no pulse.
  - `sync_in`=1 and `db_cnt`==`DEBOUNCE_CYCLES`-1 → `S_HIGH`, `level`←1, `press_pulse`←1, `hold_cnt`←0.
  - Otherwise `db_cnt`++.
- `S_HIGH`:
  - `sync_in`=0 → `S_FALL`, `db_cnt`←1.
  - Otherwise stay.
- `S_FALL`:
  - `sync_in`=1 → `S_HIGH`, `db_cnt`←0. No pulse; `hold_cnt` keeps counting.
  - `sync_in`=0 and `db_cnt`==`DEBOUNCE_CYCLES`-1 → `S_LOW`, `level`←0, `release_pulse`←1.
  - Otherwise `db_cnt`++.
- `hold_cnt`:
  - Increments every cycle in `S_HIGH` or `S_FALL` while below `LONG_PRESS_CYCLES`, then saturates.
  - `long_press_pulse`←1 on the edge where `hold_cnt` reaches `LONG_PRESS_CYCLES`. This happens at most once per press.
- Every pulse output is 0 on every cycle except the single cycle named above.
- Counter widths:
  - `db_cnt` is $clog2(`DEBOUNCE_CYCLES`+1) bits.
  - `hold_cnt` is $clog2(`LONG_PRESS_CYCLES`+1) bits.
  - Unsigned. No wrap is possible, because `hold_cnt` saturates.
- Reset mid-operation: on the next edge all state and outputs return to reset values. No pulse is emitted for a press in progress.
- A release accepted before `LONG_PRESS_CYCLES` is reached suppresses `long_press_pulse` for that press.
- Release and long-press on the same edge: if the release is accepted on the edge where `hold_cnt` would reach `LONG_PRESS_CYCLES`, only `release_pulse` fires.

## Timing
- All outputs are registered. There are no combinational paths from `sync_in` to outputs.
- Press latency:
  - If `sync_in` is first sampled 1 at edge k and stays 1, `level` and `press_pulse` are high in the cycle after edge k+`DEBOUNCE_CYCLES`-1.
  - `press_pulse` is high for exactly that one cycle.
- Release latency: symmetric with press latency, on `release_pulse`.
- Long press: if `press_pulse` is high in cycle t and the press holds, `long_press_pulse` is high in cycle t+`LONG_PRESS_CYCLES`.
- Bounce rejection: a glitch shorter than `DEBOUNCE_CYCLES` samples never changes `level` or any pulse.
- Minimum spacing: two accepted transitions are at least `DEBOUNCE_CYCLES` cycles apart.

## Structure
- Shared package `debounce_pkg` holds:
  - the state enum `debounce_state_t` (`S_LOW`, `S_RISE`, `S_HIGH`, `S_FALL`);
  - the parameter-range check constants.
- No sub-module is natural. Both counters and the FSM are inline in one module, in roughly 150 lines.
- Elaboration-time assertions enforce the parameter constraints.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=12.
1. Reset 3 cycles, `sync_in`=0 → all outputs 0; `level` stays 0 for 20 cycles.
2. `sync_in`=1 first sampled at edge 10, held → `level` and `press_pulse` high after edge 13; `press_pulse` low after edge 14.
3. Bounce: `sync_in` pattern 1,1,1,0,1,1,0 then 0 held → no `press_pulse`; `level` stays 0.
4. Press held 30 cycles after `press_pulse` at cycle t → `long_press_pulse` high only in cycle t+12. Then release → `release_pulse` exactly 4 sampled-0 edges later.
5. Press released after 6 cycles, with a 2-cycle 0-glitch in `S_HIGH` → glitch ignored; `release_pulse` fires once; no `long_press_pulse`.
6. `reset` asserted while in `S_RISE` with `db_cnt`=2 → after the next edge the state is `S_LOW` and all outputs 0; a following clean press still takes the full 4 cycles.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the pushbutton debouncer: the FSM state encoding
// and the parameter range limits checked when the debouncer is elaborated.
package debounce_pkg;

   // Four-state qualifier: two stable states and two "qualifying" states
   // in which a candidate level change is being counted.
   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } debounce_state_t;

   // A single-sample debounce window cannot distinguish bounce from a change.
   localparam int unsigned MIN_DEBOUNCE_CYCLES = 2;

   // The long-press window must extend beyond the debounce window, otherwise
   // a long press could be declared before the press itself was accepted.
   function automatic bit debounce_params_ok(input int unsigned db_cycles,
                                             input int unsigned lp_cycles);
      return (db_cycles >= MIN_DEBOUNCE_CYCLES) && (lp_cycles > db_cycles);
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// Turns one already-synchronized button level into a clean debounced level
// plus single-cycle press, release and long-press pulses.
//
// Ports:
//   clk              - system clock, rising edge
//   reset            - synchronous active-high reset
//   sync_in          - synchronized raw button level (1 = pressed)
//   level            - debounced level (registered)
//   press_pulse      - one cycle on an accepted 0->1 change
//   release_pulse    - one cycle on an accepted 1->0 change
//   long_press_pulse - one cycle when a press has been held LONG_PRESS_CYCLES
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = 50000,
   parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic sync_in,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

   // Reject illegal parameter combinations at elaboration.
   if (!debounce_params_ok(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)) begin : g_param_check
      $error("button_debouncer: need DEBOUNCE_CYCLES >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
   end

   debounce_state_t state_q, state_d;
   logic [DW-1:0]   db_cnt_q, db_cnt_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic            release_q, release_d;
   logic            long_q, long_d;
   logic            hold_run;

   // State register; every output is a flop so nothing combinational
   // reaches the downstream control FSMs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_LOW;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         db_cnt_q   <= db_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
      end
   end

   // Next-state logic. The qualifying states count consecutive samples of
   // the candidate level; db_cnt starts at 1 because the sample that left
   // the stable state already counts. hold_run marks the cycles in which the
   // press is still considered held, including a bounce in S_FALL, but not
   // the edge on which the release is accepted: that way a release landing
   // on the long-press edge suppresses the long-press pulse.
   always_comb begin
      state_d    = state_q;
      db_cnt_d   = db_cnt_q;
      hold_cnt_d = hold_cnt_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      hold_run   = 1'b0;

      case (state_q)
         S_LOW: begin
            if (sync_in) begin
               state_d  = S_RISE;
               db_cnt_d = DW'(1);
            end
         end
         S_RISE: begin
            if (!sync_in) begin
               state_d  = S_LOW;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d    = S_HIGH;
               db_cnt_d   = '0;
               level_d    = 1'b1;
               press_d    = 1'b1;
               hold_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + DW'(1);
            end
         end
         S_HIGH: begin
            hold_run = 1'b1;
            if (!sync_in) begin
               state_d  = S_FALL;
               db_cnt_d = DW'(1);
            end
         end
         S_FALL: begin
            if (sync_in) begin
               state_d  = S_HIGH;
               db_cnt_d = '0;
               hold_run = 1'b1;
            end else if (db_cnt_q == DB_LAST) begin
               state_d   = S_LOW;
               db_cnt_d  = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + DW'(1);
               hold_run = 1'b1;
            end
         end
         default: begin
            state_d  = S_LOW;
            db_cnt_d = '0;
            level_d  = 1'b0;
         end
      endcase

      // Saturating hold counter: the pulse fires only on the one edge where
      // it reaches the limit, so at most once per press.
      if (hold_run && (hold_cnt_q < HOLD_MAX)) begin
         hold_cnt_d = hold_cnt_q + HW'(1);
         if (hold_cnt_q == HOLD_LAST) begin
            long_d = 1'b1;
         end
      end
   end

   assign level            = level_q;
   assign press_pulse      = press_q;
   assign release_pulse    = release_q;
   assign long_press_pulse = long_q;

endmodule
